divider16by8_seq: RTL and testbench



---
 rtl/divider16by8_seq.sv | 157 +++++++++++++++
 tb/tb_divider16by8_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/divider16by8_seq.sv
// divider16by8_seq: sequential restoring divider, 2*WIDTH / WIDTH -> WIDTH.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready + dividend,
//   divisor on the request side; out_valid/out_ready + quotient,
//   remainder, div_zero, overflow on the result side.
module divider16by8_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero,
    output logic               overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qreg;
    logic [CW-1:0]    cnt;
    logic             dz_r;
    logic             ov_r;

    logic             accept;
    logic [WIDTH-1:0] dvd_hi;
    logic             is_zero;
    logic             is_ovf;
    logic             is_exc;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic             last;

    assign accept  = in_valid && (state == IDLE);
    assign dvd_hi  = dividend[2*WIDTH-1:WIDTH];
    assign is_zero = (divisor == '0);
    // A high half >= divisor means the quotient needs more than WIDTH bits.
    assign is_ovf  = !is_zero && (dvd_hi >= divisor);
    assign is_exc  = is_zero || is_ovf;

    // Shift {prem, qreg} left by one; the top prem bit is always 0 here
    // because the partial remainder stays below the divisor.
    assign shifted = {prem[WIDTH-1:0], qreg[WIDTH-1]};
    // One extra bit so the borrow tells us whether the trial went negative.
    assign trial   = {1'b0, shifted} - {2'b00, dvs};
    assign fits    = !trial[WIDTH+1];
    assign last    = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_exc ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode (from the state register only)
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE:    in_ready  = 1'b1;
            CALC:    in_ready  = 1'b0;
            DONE:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvs  <= '0;
            prem <= '0;
            qreg <= '0;
            cnt  <= '0;
            dz_r <= 1'b0;
            ov_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        dvs  <= divisor;
                        cnt  <= '0;
                        dz_r <= is_zero;
                        ov_r <= is_ovf;
                        if (is_exc) begin
                            // Saturated result; low half passes through.
                            prem <= {1'b0, dividend[WIDTH-1:0]};
                            qreg <= '1;
                        end else begin
                            prem <= {1'b0, dvd_hi};
                            qreg <= dividend[WIDTH-1:0];
                        end
                    end
                end
                CALC: begin
                    prem <= fits ? trial[WIDTH:0] : shifted;
                    qreg <= {qreg[WIDTH-2:0], fits};
                    cnt  <= cnt + CW'(1);
                end
                DONE: begin
                    prem <= prem;
                end
                default: begin
                    prem <= prem;
                end
            endcase
        end
    end

    assign quotient  = qreg;
    assign remainder = prem[WIDTH-1:0];
    assign div_zero  = dz_r;
    assign overflow  = ov_r;

endmodule

// File: tb/tb_divider16by8_seq.sv
// tb_divider16by8_seq: vector table, corner sequences and a random
// sweep for divider16by8_seq, with a queue-based scoreboard.
module tb_divider16by8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        overflow;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         lat;
    } exp_t;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        int          hold;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];

    divider16by8_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dd,
                                   input logic [7:0] dv);
        exp_t e;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        e.lat = 8;
        if (dv == 8'd0) begin
            e.q = 8'hFF; e.r = dd[7:0]; e.dz = 1'b1; e.lat = 0;
        end else if (dd[15:8] >= dv) begin
            e.q = 8'hFF; e.r = dd[7:0]; e.ov = 1'b1; e.lat = 0;
        end else begin
            e.q = 8'(dd / {8'd0, dv});
            e.r = 8'(dd % {8'd0, dv});
        end
        return e;
    endfunction

    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv,
                          input int hold, input exp_t e);
        exp_t g;
        int   lat;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);
        dividend  = dd;
        divisor   = dv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        sb.push_back(e);
        check("busy_after_accept", 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(posedge clk);
            #1;
            check("held", 32'({in_ready, out_valid, quotient, remainder,
                               div_zero, overflow}),
                  32'({1'b0, 1'b1, e.q, e.r, e.dz, e.ov}));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            g = sb.pop_front();
            check("quotient", 32'(quotient), 32'(g.q));
            check("remainder", 32'(remainder), 32'(g.r));
            check("flags", 32'({div_zero, overflow}), 32'({g.dz, g.ov}));
            if (g.lat != 0) begin
                check("identity", 32'(16'(quotient) * 16'(dd[15:0] == 0 ?
                      dv : dv) + 16'(remainder)), 32'(dd));
                check("rem_lt_div", 32'(remainder < dv), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release", 32'({out_valid, in_ready}), 32'd1);
    endtask

    initial begin
        int   seen;
        exp_t e;
        logic [15:0] rdd;
        logic [7:0]  rdv;

        vecs[0]  = '{16'h3039, 8'h7B, 0,  '{8'h64, 8'h2D, 1'b0, 1'b0, 8}};
        vecs[1]  = '{16'hFEFF, 8'hFF, 0,  '{8'hFF, 8'hFE, 1'b0, 1'b0, 8}};
        vecs[2]  = '{16'h1234, 8'h00, 0,  '{8'hFF, 8'h34, 1'b1, 1'b0, 0}};
        vecs[3]  = '{16'h7B00, 8'h7B, 0,  '{8'hFF, 8'h00, 1'b0, 1'b1, 0}};
        vecs[4]  = '{16'h0000, 8'h01, 0,  '{8'h00, 8'h00, 1'b0, 1'b0, 8}};
        vecs[5]  = '{16'h00FF, 8'h01, 0,  '{8'hFF, 8'h00, 1'b0, 1'b0, 8}};
        vecs[6]  = '{16'h0100, 8'h01, 0,  '{8'hFF, 8'h00, 1'b0, 1'b1, 0}};
        vecs[7]  = '{16'h00FE, 8'hFF, 0,  '{8'h00, 8'hFE, 1'b0, 1'b0, 8}};
        vecs[8]  = '{16'h3039, 8'h7B, 20, '{8'h64, 8'h2D, 1'b0, 1'b0, 8}};
        vecs[9]  = '{16'hFFFF, 8'h00, 3,  '{8'hFF, 8'hFF, 1'b1, 1'b0, 0}};
        vecs[10] = '{16'h7AFF, 8'h7B, 0,  '{8'hFF, 8'h7A, 1'b0, 1'b0, 8}};
        vecs[11] = '{16'h7B00, 8'h7B, 5,  '{8'hFF, 8'h00, 1'b0, 1'b1, 0}};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("reset_state", 32'({in_ready, out_valid, quotient, remainder,
                                  div_zero, overflow}), 32'h80000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].dd, vecs[i].dv, vecs[i].hold, vecs[i].e);
        end

        // Abort by reset during iteration 4.
        @(negedge clk);
        dividend  = 16'h3039;
        divisor   = 8'h7B;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_reset", 32'({in_ready, out_valid, quotient, remainder,
                                  div_zero, overflow}), 32'h80000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("no_valid_after_abort", 32'(seen), 32'd0);
        out_ready = 1'b0;

        // Random sweep against the reference model.
        for (int i = 0; i < 1500; i++) begin
            rdv = 8'($urandom);
            if ($urandom_range(0, 9) < 8 && rdv != 8'd0) begin
                rdd = {8'($urandom_range(0, int'(rdv) - 1)), 8'($urandom)};
            end else begin
                rdd = 16'($urandom);
            end
            e = model(rdd, rdv);
            run_op(rdd, rdv, int'($urandom_range(0, 2)), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
